// File: rtl/ssd1306_cmd_ctrl_pkg.sv
// Shared definitions for the SSD1306 command controller: opcode constants,
// addressing-mode encodings, command FSM state codes and the mode decoder.
package ssd1306_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'd0,
    MODE_VERT  = 2'd1,
    MODE_PAGE  = 2'd2
  } mode_e;

  // Multi-byte commands
  localparam logic [7:0] OP_SET_MODE   = 8'h20;
  localparam logic [7:0] OP_COL_RANGE  = 8'h21;
  localparam logic [7:0] OP_PAGE_RANGE = 8'h22;
  // Single-byte commands
  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;
`ifdef SSD1306_INVERT_EN
  localparam logic [7:0] OP_INV_OFF    = 8'hA6;
  localparam logic [7:0] OP_INV_ON     = 8'hA7;
`endif
  // Nibble-carrying command families, matched on the upper bits
  localparam logic [3:0] OP_COL_LO_PFX = 4'h0;      // 0x00-0x0F
  localparam logic [4:0] OP_COL_HI_PFX = 5'b00010;  // 0x10-0x17
  localparam logic [3:0] OP_PAGE_PFX   = 4'hB;      // 0xB0-0xBF

  // Mode code 3 is reserved on the real part; behave as page mode.
  function automatic mode_e decode_mode(input logic [1:0] a);
    if (a == 2'd3) return MODE_PAGE;
    return mode_e'(a);
  endfunction

endpackage

// File: rtl/ssd1306_cmd_ctrl_addr_gen.sv
// Column/page write pointer with window ranges and addressing modes.
// Latches the RAM address of the current pointer when a data byte is
// accepted, then advances the pointer on the same edge.
module ssd1306_cmd_ctrl_addr_gen
  import ssd1306_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int PAGES  = 12,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,          // data byte accepted
  input  logic              set_mode_i,     // arg_i[1:0] is the new mode
  input  logic              set_col_rng_i,  // start_i / arg_i are col start/end
  input  logic              set_page_rng_i, // start_i / arg_i are page start/end
  input  logic              set_col_lo_i,   // arg_i[3:0] -> col[3:0]
  input  logic              set_col_hi_i,   // arg_i[2:0] -> col[6:4]
  input  logic              set_page_i,     // arg_i[3:0] -> page
  input  logic [6:0]        start_i,
  input  logic [6:0]        arg_i,
  output logic [ADDR_W-1:0] ram_addr_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(PAGES);

  logic [CW-1:0]     col_q, col_start_q, col_end_q;
  logic [PW-1:0]     page_q, page_start_q, page_end_q;
  mode_e             mode_q;
  logic [ADDR_W-1:0] ram_addr_q;

  logic       col_wrap, page_wrap;
  logic [6:0] col7;

  function automatic logic [CW-1:0] clamp_col(input logic [6:0] v);
    if (int'(v) > WIDTH - 1) return CW'(WIDTH - 1);
    return CW'(v);
  endfunction

  function automatic logic [PW-1:0] clamp_page(input logic [3:0] v);
    if (int'(v) > PAGES - 1) return PW'(PAGES - 1);
    return PW'(v);
  endfunction

  // A pointer wraps at the window end or at the physical edge, whichever first.
  assign col_wrap  = (col_q == col_end_q) || (col_q == CW'(WIDTH - 1));
  assign page_wrap = (page_q == page_end_q) || (page_q == PW'(PAGES - 1));
  assign col7      = 7'(col_q);

  // Pointer, window and mode state; data advance and commands never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(WIDTH - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      mode_q       <= MODE_PAGE;
      ram_addr_q   <= '0;
    end else if (adv_i) begin
      // Address uses the pointer before it moves.
      ram_addr_q <= ADDR_W'(page_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
      case (mode_q)
        MODE_HORIZ: begin
          if (col_wrap) begin
            col_q  <= col_start_q;
            page_q <= page_wrap ? page_start_q : page_q + PW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        MODE_VERT: begin
          if (page_wrap) begin
            page_q <= page_start_q;
            col_q  <= col_wrap ? col_start_q : col_q + CW'(1);
          end else begin
            page_q <= page_q + PW'(1);
          end
        end
        default: col_q <= col_wrap ? col_start_q : col_q + CW'(1);
      endcase
    end else begin
      if (set_mode_i) mode_q <= decode_mode(arg_i[1:0]);
      if (set_col_rng_i) begin
        col_start_q <= clamp_col(start_i);
        col_end_q   <= clamp_col(arg_i);
        col_q       <= clamp_col(start_i);
      end
      if (set_page_rng_i) begin
        page_start_q <= clamp_page(start_i[3:0]);
        page_end_q   <= clamp_page(arg_i[3:0]);
        page_q       <= clamp_page(start_i[3:0]);
      end
      if (set_col_lo_i) col_q  <= clamp_col({col7[6:4], arg_i[3:0]});
      if (set_col_hi_i) col_q  <= clamp_col({arg_i[2:0], col7[3:0]});
      if (set_page_i)   page_q <= clamp_page(arg_i[3:0]);
    end
  end

  assign ram_addr_o = ram_addr_q;

endmodule

// File: rtl/ssd1306_cmd_ctrl.sv
// SSD1306-compatible command/address controller between an SPI byte receiver
// and the bitmap RAM. Command bytes (DC_i=0) run through a small argument FSM
// and update the pointer/flags; data bytes (DC_i=1) become one-cycle RAM writes.
// Optional feature macro: SSD1306_INVERT_EN enables 0xA6/0xA7 inverse video.
module ssd1306_cmd_ctrl
  import ssd1306_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 96,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT / 8)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CS_i,
  input  logic              DC_i,
  input  logic [7:0]        Byte_i,
  input  logic              ByteValid_i,
  output logic [ADDR_W-1:0] RamAddr_o,
  output logic [7:0]        RamData_o,
  output logic              RamWrite_o,
  output logic              DisplayOn_o,
  output logic              Invert_o
);

  localparam int PAGES = HEIGHT / 8;

  state_e     state_q;
  logic [7:0] opc_q;
  logic [6:0] arg1_q;
  logic       disp_q;
  logic       wr_q;
  logic [7:0] data_q;

  logic acc, is_cmd, is_data, in_idle;
  logic set_mode, set_col_rng, set_page_rng, set_col_lo, set_col_hi, set_page;

  assign acc     = ByteValid_i & ~CS_i;
  assign is_cmd  = acc & ~DC_i;
  assign is_data = acc & DC_i;
  assign in_idle = (state_q == ST_IDLE);

  assign set_mode     = is_cmd & (state_q == ST_ARG1) & (opc_q == OP_SET_MODE);
  assign set_col_rng  = is_cmd & (state_q == ST_ARG2) & (opc_q == OP_COL_RANGE);
  assign set_page_rng = is_cmd & (state_q == ST_ARG2) & (opc_q == OP_PAGE_RANGE);
  assign set_col_lo   = is_cmd & in_idle & (Byte_i[7:4] == OP_COL_LO_PFX);
  assign set_col_hi   = is_cmd & in_idle & (Byte_i[7:3] == OP_COL_HI_PFX);
  assign set_page     = is_cmd & in_idle & (Byte_i[7:4] == OP_PAGE_PFX);

`ifdef SSD1306_INVERT_EN
  logic inv_q;
`endif

  // Command FSM, display flags and the registered write strobe/data.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
      arg1_q  <= '0;
      disp_q  <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
`ifdef SSD1306_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      wr_q <= is_data;
      if (is_data) data_q <= Byte_i;
      // Deselect or a data byte drops any half-received command.
      if (CS_i || is_data) begin
        state_q <= ST_IDLE;
      end else if (is_cmd) begin
        case (state_q)
          ST_IDLE: begin
            if (Byte_i inside {OP_SET_MODE, OP_COL_RANGE, OP_PAGE_RANGE}) begin
              opc_q   <= Byte_i;
              state_q <= ST_ARG1;
            end
            if (Byte_i == OP_DISP_ON)  disp_q <= 1'b1;
            if (Byte_i == OP_DISP_OFF) disp_q <= 1'b0;
`ifdef SSD1306_INVERT_EN
            if (Byte_i == OP_INV_ON)   inv_q  <= 1'b1;
            if (Byte_i == OP_INV_OFF)  inv_q  <= 1'b0;
`endif
          end
          ST_ARG1: begin
            arg1_q  <= Byte_i[6:0];
            state_q <= (opc_q == OP_SET_MODE) ? ST_IDLE : ST_ARG2;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  ssd1306_cmd_ctrl_addr_gen #(
    .WIDTH  (WIDTH),
    .PAGES  (PAGES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk            (Clock),
    .rst_n          (Reset),
    .adv_i          (is_data),
    .set_mode_i     (set_mode),
    .set_col_rng_i  (set_col_rng),
    .set_page_rng_i (set_page_rng),
    .set_col_lo_i   (set_col_lo),
    .set_col_hi_i   (set_col_hi),
    .set_page_i     (set_page),
    .start_i        (arg1_q),
    .arg_i          (Byte_i[6:0]),
    .ram_addr_o     (RamAddr_o)
  );

  assign RamData_o   = data_q;
  assign RamWrite_o  = wr_q;
  assign DisplayOn_o = disp_q;
`ifdef SSD1306_INVERT_EN
  assign Invert_o    = inv_q;
`else
  assign Invert_o    = 1'b0;
`endif

endmodule

// File: tb/tb_ssd1306_cmd_ctrl.sv
// Bench for ssd1306_cmd_ctrl: directed command/data sequences, a queue-based
// reference model checked every cycle, plus literal address expectations.
module tb_ssd1306_cmd_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        CS_i, DC_i, ByteValid_i;
  logic [7:0]  Byte_i;
  logic [10:0] RamAddr_o;
  logic [7:0]  RamData_o;
  logic        RamWrite_o, DisplayOn_o, Invert_o;

  ssd1306_cmd_ctrl dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .CS_i        (CS_i),
    .DC_i        (DC_i),
    .Byte_i      (Byte_i),
    .ByteValid_i (ByteValid_i),
    .RamAddr_o   (RamAddr_o),
    .RamData_o   (RamData_o),
    .RamWrite_o  (RamWrite_o),
    .DisplayOn_o (DisplayOn_o),
    .Invert_o    (Invert_o)
  );

  always #5 Clock = ~Clock;

`ifdef SSD1306_INVERT_EN
  localparam int INV_EXP = 1;
`else
  localparam int INV_EXP = 0;
`endif

  int vectors = 0, miscompares = 0;

  // ---------------- reference model ----------------
  int   m_col = 0, m_page = 0, m_cs = 0, m_ce = 127, m_ps = 0, m_pe = 11, m_mode = 2;
  int   m_addr = 0, m_data = 0;
  bit   m_we = 0, m_disp = 0, m_inv = 0;
  logic [7:0] cq[$];  // bytes of a multi-byte command collected so far

  function automatic int min11(input int v);
    return (v > 11) ? 11 : v;
  endfunction

  task automatic m_single(input logic [7:0] b);
    if (b < 8'h10)                   m_col  = (m_col & 'h70) | int'(b[3:0]);
    else if (b < 8'h18)              m_col  = (m_col & 'h0F) | (int'(b[2:0]) << 4);
    else if (b[7:4] == 4'hB)         m_page = min11(int'(b[3:0]));
    else if (b == 8'hAF)             m_disp = 1;
    else if (b == 8'hAE)             m_disp = 0;
`ifdef SSD1306_INVERT_EN
    else if (b == 8'hA7)             m_inv  = 1;
    else if (b == 8'hA6)             m_inv  = 0;
`endif
  endtask

  task automatic m_cmd(input logic [7:0] b);
    logic [7:0] a, e;
    if (cq.size() == 0) begin
      if (b == 8'h20 || b == 8'h21 || b == 8'h22) cq.push_back(b);
      else m_single(b);
    end else begin
      cq.push_back(b);
      if (cq[0] == 8'h20) begin
        m_mode = (b[1:0] == 2'd3) ? 2 : int'(b[1:0]);
        cq.delete();
      end else if (cq.size() == 3) begin
        a = cq[1];
        e = cq[2];
        if (cq[0] == 8'h21) begin
          m_cs = int'(a[6:0]); m_ce = int'(e[6:0]); m_col = m_cs;
        end else begin
          m_ps = min11(int'(a[3:0])); m_pe = min11(int'(e[3:0])); m_page = m_ps;
        end
        cq.delete();
      end
    end
  endtask

  task automatic m_advance();
    bit cw, pw;
    cw = (m_col == m_ce) || (m_col == 127);
    pw = (m_page == m_pe) || (m_page == 11);
    if (m_mode == 0) begin
      if (cw) begin m_col = m_cs; m_page = pw ? m_ps : m_page + 1; end
      else m_col++;
    end else if (m_mode == 1) begin
      if (pw) begin m_page = m_ps; m_col = cw ? m_cs : m_col + 1; end
      else m_page++;
    end else begin
      m_col = cw ? m_cs : m_col + 1;
    end
  endtask

  // Model advances on the same edges the design samples inputs on.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 11; m_mode = 2;
      m_addr = 0; m_data = 0; m_we = 0; m_disp = 0; m_inv = 0;
      cq.delete();
    end else begin
      m_we = 0;
      if (CS_i) cq.delete();
      else if (ByteValid_i) begin
        if (DC_i) begin
          cq.delete();
          m_we   = 1;
          m_addr = m_page * 128 + m_col;
          m_data = int'(Byte_i);
          m_advance();
        end else begin
          m_cmd(Byte_i);
        end
      end
    end
  end

  // ---------------- checking ----------------
  int wlog[$], dlog[$];

  task automatic compare();
    bit bad;
    bad = 0;
    if (RamWrite_o != m_we || DisplayOn_o != m_disp || Invert_o != m_inv) bad = 1;
    if (m_we && (int'(RamAddr_o) != m_addr || int'(RamData_o) != m_data)) bad = 1;
    if (!Reset && (RamAddr_o != 0 || RamData_o != 0)) bad = 1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL cycle t=%0t: we=%0b/%0b addr=%0d/%0d data=%02h/%02h disp=%0b/%0b inv=%0b/%0b (got/want)",
               $time, RamWrite_o, m_we, RamAddr_o, m_addr, RamData_o, m_data,
               DisplayOn_o, m_disp, Invert_o, m_inv);
    end
    if (RamWrite_o) begin
      wlog.push_back(int'(RamAddr_o));
      dlog.push_back(int'(RamData_o));
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Every stimulus cycle: check at negedge, then drive the next inputs.
  task automatic tick(input logic vld, input logic dc, input logic [7:0] b, input logic cs);
    @(negedge Clock);
    compare();
    ByteValid_i = vld; DC_i = dc; Byte_i = b; CS_i = cs;
  endtask

  task automatic cmd(input logic [7:0] b); tick(1'b1, 1'b0, b, 1'b0); endtask
  task automatic dat(input logic [7:0] b); tick(1'b1, 1'b1, b, 1'b0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  int t3_exp[5] = '{2, 130, 3, 131, 2};

  initial begin
    CS_i = 1'b1; DC_i = 1'b0; Byte_i = 8'h00; ByteValid_i = 1'b0;
    idle(3);
    chk("rst_we",   int'(RamWrite_o), 0);
    chk("rst_addr", int'(RamAddr_o), 0);
    chk("rst_data", int'(RamData_o), 0);
    chk("rst_disp", int'(DisplayOn_o), 0);
    chk("rst_inv",  int'(Invert_o), 0);
    Reset = 1'b1;
    idle(2);

    // 1: page mode default, 2048 bytes wrap over columns 0..127 of page 0
    for (int i = 0; i < 2048; i++) dat((i % 2) ? 8'h00 : 8'hFF);
    idle(2);
    chk("t1_count",     wlog.size(), 2048);
    chk("t1_addr128",   wlog[128], 0);
    chk("t1_last_addr", wlog[2047], 127);
    chk("t1_last_data", dlog[2047], 8'h00);
    wlog.delete(); dlog.delete();

    // 2: horizontal mode over the full screen
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h00); cmd(8'h7F);
    cmd(8'h22); cmd(8'h00); cmd(8'h0B);
    for (int i = 0; i < 1537; i++) dat(8'(i));
    idle(2);
    chk("t2_addr1535", wlog[1535], 1535);
    chk("t2_addr1536", wlog[1536], 0);
    wlog.delete(); dlog.delete();

    // 3: vertical mode inside a 2x2 window
    cmd(8'h20); cmd(8'h01);
    cmd(8'h21); cmd(8'h02); cmd(8'h03);
    cmd(8'h22); cmd(8'h00); cmd(8'h01);
    for (int i = 0; i < 5; i++) dat(8'h30 + 8'(i));
    idle(2);
    chk("t3_count", wlog.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t3_addr%0d", i), wlog[i], t3_exp[i]);
    wlog.delete(); dlog.delete();

    // 4: page/column nibble commands
    cmd(8'hB5); cmd(8'h03); cmd(8'h12); dat(8'hAA);
    idle(1);
    chk("t4_we_next_cycle", int'(RamWrite_o), 1);
    idle(1);
    chk("t4_addr", wlog[0], 675);
    chk("t4_data", dlog[0], 8'hAA);
    wlog.delete(); dlog.delete();

    // 5: CS pulse aborts 0x21; vertical advance gives page 6, col 35
    cmd(8'h21); cmd(8'h10); tick(1'b0, 1'b0, 8'h00, 1'b1); dat(8'h55);
    cmd(8'hAF);
    idle(2);
    chk("t5_addr", wlog[0], 803);
    chk("t5_disp", int'(DisplayOn_o), 1);
    // data byte in the middle of 0x22 aborts it and writes at page 7
    cmd(8'h22); cmd(8'h03); dat(8'h11);
    idle(2);
    chk("t5_abort_addr", wlog[1], 931);
    wlog.delete(); dlog.delete();

    // 6: invert, unknown opcode, display off/on, reset mid-stream
    cmd(8'hA7); idle(1);
    chk("t6_inv", int'(Invert_o), INV_EXP);
    cmd(8'hE3); cmd(8'hAE); idle(1);
    chk("t6_disp_off", int'(DisplayOn_o), 0);
    cmd(8'hAF);
    dat(8'h77);
    #6;
    chk("t6_pre_rst_we", int'(RamWrite_o), 1);
    Reset = 1'b0; ByteValid_i = 1'b0;
    #1;
    chk("t6_rst_we",   int'(RamWrite_o), 0);
    chk("t6_rst_disp", int'(DisplayOn_o), 0);
    chk("t6_rst_inv",  int'(Invert_o), 0);
    chk("t6_rst_addr", int'(RamAddr_o), 0);
    idle(2);
    Reset = 1'b1;
    idle(1);
    wlog.delete(); dlog.delete();
    dat(8'h5A); dat(8'hA5);
    idle(2);
    chk("t6_post_rst_addr0", wlog[0], 0);
    chk("t6_post_rst_addr1", wlog[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
